// File: rtl/pipe_stage_chain.sv
// Multi-stage pipeline register chain with freeze (stall), flush (kill) and
// saturating stall/flush/bubble statistics counters.
module pipe_stage_chain #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned PC_W       = 32,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned FLUSH_ZERO = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_data,
  output logic [3:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef struct packed {
    logic              valid;
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] data;
  } stage_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  stage_t           r_stage [DEPTH];
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;

  stage_t           w_in;
  logic             w_advance;
  logic             w_stall;
  logic             w_bubble;
  logic [3:0]       w_occ;

  // Bubbles enter with pc/data forced to zero so they are recognisable downstream.
  always_comb begin
    w_in.valid = in_valid;
    w_in.pc    = in_valid ? in_pc   : '0;
    w_in.data  = in_valid ? in_data : '0;
  end

  assign w_advance = ~freeze & ~flush;
  assign w_stall   = freeze & ~flush;
  assign w_bubble  = w_advance & ~in_valid;

  // Stage chain: reset > flush > freeze > advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i].valid <= 1'b0;
        if (FLUSH_ZERO != 0) begin
          r_stage[i].pc   <= '0;
          r_stage[i].data <= '0;
        end
      end
    end else if (!freeze) begin
      r_stage[0] <= w_in;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (flush && (r_flush_cnt != CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
      if (w_bubble && (r_bubble_cnt != CNT_MAX)) begin
        r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
      end
    end
  end

  // Popcount of stage valid bits; driven only from registers.
  always_comb begin
    w_occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_occ = w_occ + 4'(r_stage[i].valid);
    end
  end

  assign out_valid  = r_stage[DEPTH-1].valid;
  assign out_pc     = r_stage[DEPTH-1].pc;
  assign out_data   = r_stage[DEPTH-1].data;
  assign occupancy  = w_occ;
  assign stall_cnt  = r_stall_cnt;
  assign flush_cnt  = r_flush_cnt;
  assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Bench for pipe_stage_chain: directed scenarios plus randomized traffic checked
// against a queue-style reference model; a second instance uses CNT_W=4, FLUSH_ZERO=0.
module tb_pipe_stage_chain;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_data = '0;

  logic        out_valid, a_out_valid;
  logic [31:0] out_pc, a_out_pc, out_data, a_out_data;
  logic [3:0]  occupancy, a_occupancy;
  logic [15:0] stall_cnt, flush_cnt, bubble_cnt;
  logic [3:0]  a_stall_cnt, a_flush_cnt, a_bubble_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_chain #(.DATA_W(32), .PC_W(32), .DEPTH(DEPTH), .CNT_W(16), .FLUSH_ZERO(1)) u_dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .in_valid(in_valid),
    .in_pc(in_pc), .in_data(in_data), .out_valid(out_valid), .out_pc(out_pc),
    .out_data(out_data), .occupancy(occupancy), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt), .bubble_cnt(bubble_cnt));

  pipe_stage_chain #(.DATA_W(32), .PC_W(32), .DEPTH(DEPTH), .CNT_W(4), .FLUSH_ZERO(0)) u_alt (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .in_valid(in_valid),
    .in_pc(in_pc), .in_data(in_data), .out_valid(a_out_valid), .out_pc(a_out_pc),
    .out_data(a_out_data), .occupancy(a_occupancy), .stall_cnt(a_stall_cnt),
    .flush_cnt(a_flush_cnt), .bubble_cnt(a_bubble_cnt));

  // Reference model: index 0 = newest entry; model 0 zeroes on flush, model 1 keeps pc/data.
  typedef struct { bit v; logic [31:0] pc; logic [31:0] d; } ent_t;
  ent_t mdl [2][DEPTH];
  int   scnt [2];
  int   fcnt [2];
  int   bcnt [2];

  task automatic cycle(input bit r, input bit fz, input bit fl, input bit v,
                       input logic [31:0] pc, input logic [31:0] d);
    ent_t e;
    rst = r; freeze = fz; flush = fl; in_valid = v; in_pc = pc; in_data = d;
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      int cap;
      cap = (m == 0) ? 65535 : 15;
      if (r) begin
        for (int i = 0; i < DEPTH; i++) mdl[m][i] = '{1'b0, 32'd0, 32'd0};
        scnt[m] = 0; fcnt[m] = 0; bcnt[m] = 0;
      end else if (fl) begin
        for (int i = 0; i < DEPTH; i++) begin
          mdl[m][i].v = 1'b0;
          if (m == 0) begin mdl[m][i].pc = '0; mdl[m][i].d = '0; end
        end
        if (fcnt[m] < cap) fcnt[m]++;
      end else if (fz) begin
        if (scnt[m] < cap) scnt[m]++;
      end else begin
        e.v = v; e.pc = v ? pc : 32'd0; e.d = v ? d : 32'd0;
        for (int i = DEPTH - 1; i > 0; i--) mdl[m][i] = mdl[m][i-1];
        mdl[m][0] = e;
        if (!v && bcnt[m] < cap) bcnt[m]++;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 1, 1, 1, 32'hdead, 32'hbeef);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0h exp 0", out_valid); end
    checks++; if (out_pc !== 32'd0) begin errors++; $display("FAIL rst_pc: got %0h exp 0", out_pc); end
    checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL rst_data: got %0h exp 0", out_data); end
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL rst_occ: got %0d exp 0", occupancy); end
    checks++; if ({stall_cnt, flush_cnt, bubble_cnt} !== 48'd0)
      begin errors++; $display("FAIL rst_cnt: got %0h %0h %0h exp 0", stall_cnt, flush_cnt, bubble_cnt); end
  endtask

  task automatic test_latency_freeze();
    logic [31:0] d0, d1;
    d0 = $urandom; d1 = $urandom;
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 32'd0, d0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_early: got %0h exp 0", out_valid); end
    cycle(0, 0, 0, 1, 32'd4, d1);
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'd0 || out_data !== d0)
      begin errors++; $display("FAIL lat_first: got v=%0h pc=%0h d=%0h exp v=1 pc=0 d=%0h", out_valid, out_pc, out_data, d0); end
    cycle(0, 0, 0, 1, 32'd8, $urandom);
    checks++; if (out_pc !== 32'd4 || out_data !== d1) begin errors++; $display("FAIL lat_second: got pc=%0h d=%0h exp pc=4 d=%0h", out_pc, out_data, d1); end
    checks++; if (occupancy !== 4'd2) begin errors++; $display("FAIL lat_occ: got %0d exp 2", occupancy); end
    for (int k = 1; k <= 3; k++) begin
      cycle(0, 1, 0, $urandom_range(0, 1), $urandom, $urandom);
      checks++; if (out_pc !== 32'd4 || occupancy !== 4'd2 || int'(stall_cnt) !== k)
        begin errors++; $display("FAIL frz_hold%0d: got pc=%0h occ=%0d stall=%0d exp pc=4 occ=2 stall=%0d", k, out_pc, occupancy, stall_cnt, k); end
    end
    cycle(0, 0, 0, 1, 32'd12, $urandom);
    checks++; if (out_pc !== 32'd8 || out_valid !== 1'b1) begin errors++; $display("FAIL frz_resume: got pc=%0h v=%0h exp pc=8 v=1", out_pc, out_valid); end
    cycle(0, 0, 0, 1, 32'd16, $urandom);
    checks++; if (out_pc !== 32'd12) begin errors++; $display("FAIL frz_next: got pc=%0h exp c", out_pc); end
  endtask

  task automatic test_flush_freeze();
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 32'h10, $urandom);
    cycle(0, 0, 0, 1, 32'h14, $urandom);
    cycle(0, 1, 1, 1, 32'h100, $urandom);
    checks++; if (out_valid !== 1'b0 || occupancy !== 4'd0 || out_pc !== 32'd0 || out_data !== 32'd0)
      begin errors++; $display("FAIL fl_zero: got v=%0h occ=%0d pc=%0h d=%0h exp all 0", out_valid, occupancy, out_pc, out_data); end
    checks++; if (flush_cnt !== 16'd1 || stall_cnt !== 16'd0)
      begin errors++; $display("FAIL fl_cnt: got flush=%0d stall=%0d exp 1 0", flush_cnt, stall_cnt); end
    checks++; if (a_out_valid !== 1'b0 || a_out_pc !== 32'h10 || a_occupancy !== 4'd0)
      begin errors++; $display("FAIL fl_keep: got v=%0h pc=%0h occ=%0d exp v=0 pc=10 occ=0", a_out_valid, a_out_pc, a_occupancy); end
    cycle(0, 0, 0, 1, 32'h200, $urandom);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl_discard: got v=%0h pc=%0h exp v=0", out_valid, out_pc); end
    cycle(0, 0, 0, 1, 32'h204, $urandom);
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h200) begin errors++; $display("FAIL fl_post: got v=%0h pc=%0h exp v=1 pc=200", out_valid, out_pc); end
  endtask

  task automatic test_bubbles();
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, $urandom, $urandom);
    cycle(0, 0, 0, 0, $urandom, $urandom);
    checks++; if (out_valid !== 1'b0 || out_pc !== 32'd0 || out_data !== 32'd0)
      begin errors++; $display("FAIL bub_first: got v=%0h pc=%0h d=%0h exp 0 0 0", out_valid, out_pc, out_data); end
    cycle(0, 0, 0, 1, 32'h40, $urandom);
    checks++; if (out_valid !== 1'b0 || out_pc !== 32'd0 || out_data !== 32'd0)
      begin errors++; $display("FAIL bub_second: got v=%0h pc=%0h d=%0h exp 0 0 0", out_valid, out_pc, out_data); end
    cycle(0, 0, 0, 1, 32'h44, $urandom);
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h40) begin errors++; $display("FAIL bub_after: got v=%0h pc=%0h exp 1 40", out_valid, out_pc); end
    checks++; if (bubble_cnt !== 16'd2) begin errors++; $display("FAIL bub_cnt: got %0d exp 2", bubble_cnt); end
  endtask

  task automatic test_saturation();
    cycle(1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 20; k++) begin
      cycle(0, 1, 0, $urandom_range(0, 1), $urandom, $urandom);
      if (k == 15) begin
        checks++; if (a_stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_reach: got %0d exp 15", a_stall_cnt); end
      end
    end
    checks++; if (a_stall_cnt !== 4'd15 || stall_cnt !== 16'd20)
      begin errors++; $display("FAIL sat_20: got alt=%0d main=%0d exp 15 20", a_stall_cnt, stall_cnt); end
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 32'h80, 0);
    checks++; if (a_stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_stay: got %0d exp 15", a_stall_cnt); end
  endtask

  task automatic test_reset_mid();
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 32'h20, $urandom);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 1, 1, 32'h24, $urandom);
    cycle(0, 0, 0, 1, 32'h28, $urandom);
    cycle(0, 0, 0, 1, 32'h2c, $urandom);
    cycle(1, $urandom_range(0, 1), $urandom_range(0, 1), 1, 32'h30, $urandom);
    checks++; if (out_valid !== 1'b0 || out_pc !== 32'd0 || out_data !== 32'd0 || occupancy !== 4'd0)
      begin errors++; $display("FAIL rmid_out: got v=%0h pc=%0h d=%0h occ=%0d exp 0", out_valid, out_pc, out_data, occupancy); end
    checks++; if ({stall_cnt, flush_cnt, bubble_cnt} !== 48'd0)
      begin errors++; $display("FAIL rmid_cnt: got %0d %0d %0d exp 0", stall_cnt, flush_cnt, bubble_cnt); end
    cycle(0, 0, 0, 1, 32'h300, $urandom);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_early: got v=%0h exp 0", out_valid); end
    cycle(0, 0, 0, 1, 32'h304, $urandom);
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h300) begin errors++; $display("FAIL rmid_lat: got v=%0h pc=%0h exp 1 300", out_valid, out_pc); end
  endtask

  task automatic test_random();
    cycle(1, 0, 0, 0, 0, 0);
    for (int n = 0; n < 600; n++) begin
      cycle($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 10,
            $urandom_range(0, 99) < 70, $urandom, $urandom);
      for (int m = 0; m < 2; m++) begin
        ent_t e;
        int occ;
        logic v;
        logic [31:0] pc, d;
        int go, gs, gf, gb;
        e = mdl[m][DEPTH-1];
        occ = 0;
        for (int i = 0; i < DEPTH; i++) occ += int'(mdl[m][i].v);
        v  = (m == 0) ? out_valid : a_out_valid;
        pc = (m == 0) ? out_pc : a_out_pc;
        d  = (m == 0) ? out_data : a_out_data;
        go = (m == 0) ? int'(occupancy) : int'(a_occupancy);
        gs = (m == 0) ? int'(stall_cnt) : int'(a_stall_cnt);
        gf = (m == 0) ? int'(flush_cnt) : int'(a_flush_cnt);
        gb = (m == 0) ? int'(bubble_cnt) : int'(a_bubble_cnt);
        checks++; if (v !== e.v || pc !== e.pc || d !== e.d)
          begin errors++; $display("FAIL rnd_out n=%0d m=%0d: got v=%0h pc=%0h d=%0h exp v=%0h pc=%0h d=%0h", n, m, v, pc, d, e.v, e.pc, e.d); end
        checks++; if (go !== occ) begin errors++; $display("FAIL rnd_occ n=%0d m=%0d: got %0d exp %0d", n, m, go, occ); end
        checks++; if (gs !== scnt[m] || gf !== fcnt[m] || gb !== bcnt[m])
          begin errors++; $display("FAIL rnd_cnt n=%0d m=%0d: got %0d %0d %0d exp %0d %0d %0d", n, m, gs, gf, gb, scnt[m], fcnt[m], bcnt[m]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency_freeze();
    test_flush_freeze();
    test_bubbles();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
